// File: rtl/commit_trace_tx.sv
// rtl/commit_trace_tx.sv - commit trace record producer with FIFO and end-of-run statistics
// Purpose: packs per-cycle retire events into typed trace records (REG, LOAD, STORE), buffers
// them in a circular FIFO and streams them out on a valid/ready port. After halt the FIFO is
// drained, then six statistics records are sent straight from the counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reg_write/write_reg/
//   write_data               register file write of the retiring instruction
//   mem_read/mem_write/
//   mem_addr/mem_data_in/
//   mem_data_out             committed load/store
//   halt                     halt committed
//   icache_*/dcache_*        cache request/hit strobes
//   rec_valid/rec_ready      output record handshake
//   rec_type/rec_tag/
//   rec_a/rec_b              output record payload
//   overflow                 sticky: a cycle's records were dropped
//   done                     every record including the statistics has been sent
module commit_trace_tx #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write,
    input  logic [2:0]  write_reg,
    input  logic [15:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    input  logic        halt,
    input  logic        icache_req,
    input  logic        icache_hit,
    input  logic        dcache_req,
    input  logic        dcache_hit,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [1:0]  rec_type,
    output logic [2:0]  rec_tag,
    output logic [15:0] rec_a,
    output logic [15:0] rec_b,
    output logic        overflow,
    output logic        done
);
    localparam int AW    = $clog2(DEPTH);
    localparam int AW1   = AW + 1;
    localparam int REC_W = 37;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_STATS, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [REC_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    // Counter order matches the STAT tag order: cycle, inst, dcache_hit, icache_hit,
    // dcache_req, icache_req.
    logic [CNT_W-1:0] r_cnt [6];
    logic [2:0]       r_stat_tag;
    logic             r_overflow;

    logic [1:0]       w_n;
    logic [AW:0]      w_free;
    logic             w_run;
    logic             w_enq;
    logic             w_xfer;
    logic             w_deq;
    logic [AW-1:0]    w_off_load;
    logic [AW-1:0]    w_off_store;
    logic [5:0]       w_inc;
    logic [CNT_W-1:0] w_stat_cnt;

    assign w_run      = (r_state == S_RUN);
    assign w_n        = {1'b0, reg_write} + {1'b0, mem_read} + {1'b0, mem_write};
    // Free space is taken before this cycle's dequeue, so a full FIFO drops even if
    // the sink is accepting in the same cycle.
    assign w_free     = AW1'(DEPTH) - r_count;
    assign w_enq      = w_run && (AW1'(w_n) <= w_free);
    assign w_xfer     = rec_valid && rec_ready;
    assign w_deq      = w_xfer && ((r_state == S_RUN) || (r_state == S_DRAIN));
    // Records are packed densely in REG, LOAD, STORE order.
    assign w_off_load  = AW'(reg_write);
    assign w_off_store = AW'(reg_write) + AW'(mem_read);
    assign w_inc      = {icache_req, dcache_req, icache_hit, dcache_hit,
                         halt | reg_write | mem_write, 1'b1};
    assign w_stat_cnt = r_cnt[r_stat_tag];
    assign overflow   = r_overflow;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            if (reg_write) r_mem[r_wr_ptr] <= {2'd0, write_reg, write_data, 16'h0000};
            if (mem_read)  r_mem[r_wr_ptr + w_off_load]  <= {2'd1, 3'd0, mem_addr, mem_data_out};
            if (mem_write) r_mem[r_wr_ptr + w_off_store] <= {2'd2, 3'd0, mem_addr, mem_data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_stat_tag <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < 6; i++) r_cnt[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(w_n);
            if (w_run && !w_enq) r_overflow <= 1'b1;
            if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (w_enq ? AW1'(w_n) : AW1'(0)) - (w_deq ? AW1'(1) : AW1'(0));
            if (w_run) begin
                for (int i = 0; i < 6; i++) begin
                    if (w_inc[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
            if ((r_state == S_STATS) && w_xfer) r_stat_tag <= r_stat_tag + 3'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rec_valid   = 1'b0;
        rec_type    = 2'd0;
        rec_tag     = 3'd0;
        rec_a       = 16'h0000;
        rec_b       = 16'h0000;
        done        = 1'b0;
        case (r_state)
            S_RUN, S_DRAIN: begin
                if (r_count != '0) begin
                    rec_valid = 1'b1;
                    {rec_type, rec_tag, rec_a, rec_b} = r_mem[r_rd_ptr];
                end
                if ((r_state == S_RUN) && halt) w_state_nxt = S_DRAIN;
                if ((r_state == S_DRAIN) && (r_count == '0)) w_state_nxt = S_STATS;
            end
            S_STATS: begin
                rec_valid = 1'b1;
                rec_type  = 2'd3;
                rec_tag   = r_stat_tag;
                rec_a     = 16'(w_stat_cnt >> 16);
                rec_b     = w_stat_cnt[15:0];
                if (rec_ready && (r_stat_tag == 3'd5)) w_state_nxt = S_DONE;
            end
            S_DONE: done = 1'b1;
            default: w_state_nxt = S_RUN;
        endcase
    end
endmodule

// File: tb/tb_commit_trace_tx.sv
// tb/tb_commit_trace_tx.sv - scoreboard bench for commit_trace_tx
module tb_commit_trace_tx;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_write = 0, mem_read = 0, mem_write = 0, halt = 0;
    logic [2:0]  write_reg = 0;
    logic [15:0] write_data = 0, mem_addr = 0, mem_data_in = 0, mem_data_out = 0;
    logic        icache_req = 0, icache_hit = 0, dcache_req = 0, dcache_hit = 0;
    logic        rec_valid, rec_ready = 0;
    logic [1:0]  rec_type;
    logic [2:0]  rec_tag;
    logic [15:0] rec_a, rec_b;
    logic        overflow, done;

    commit_trace_tx #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .halt(halt),
        .icache_req(icache_req), .icache_hit(icache_hit),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_type(rec_type),
        .rec_tag(rec_tag), .rec_a(rec_a), .rec_b(rec_b),
        .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [36:0] sb [$];
    bit          exp_ovf = 0;
    int unsigned m_cnt [6];
    bit          hold_pending = 0;
    logic [36:0] held;
    logic [36:0] cur;
    logic [36:0] exp_rec;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reg_write = 0; mem_read = 0; mem_write = 0; halt = 0;
        icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
    endtask

    task automatic random_inputs();
        reg_write    = 1'($urandom);
        write_reg    = 3'($urandom);
        write_data   = 16'($urandom);
        mem_read     = ($urandom_range(0, 2) == 0);
        mem_write    = ($urandom_range(0, 2) == 0);
        mem_addr     = 16'($urandom);
        mem_data_in  = 16'($urandom);
        mem_data_out = 16'($urandom);
        icache_req   = 1'($urandom);
        icache_hit   = 1'($urandom);
        dcache_req   = 1'($urandom);
        dcache_hit   = 1'($urandom);
    endtask

    // Reference model for one RUN cycle, using the inputs already driven this cycle.
    task automatic model_run();
        int          n;
        logic [31:0] v;
        check("overflow", overflow, exp_ovf);
        n = int'(reg_write) + int'(mem_read) + int'(mem_write);
        if (n > DEPTH - sb.size()) begin
            exp_ovf = 1;
        end else begin
            if (reg_write) sb.push_back({2'd0, write_reg, write_data, 16'h0000});
            if (mem_read)  sb.push_back({2'd1, 3'd0, mem_addr, mem_data_out});
            if (mem_write) sb.push_back({2'd2, 3'd0, mem_addr, mem_data_in});
        end
        for (int i = 0; i < 6; i++) begin
            bit inc;
            case (i)
                0: inc = 1;
                1: inc = halt | reg_write | mem_write;
                2: inc = dcache_hit;
                3: inc = icache_hit;
                4: inc = dcache_req;
                default: inc = icache_req;
            endcase
            if (inc && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i]++;
        end
        if (halt) begin
            for (int t = 0; t < 6; t++) begin
                v = m_cnt[t];
                sb.push_back({2'd3, 3'(t), v[31:16], v[15:0]});
            end
        end
    endtask

    task automatic do_reset();
        rst = 1;
        rec_ready = 0;
        idle_inputs();
        next_cycle();
        next_cycle();
        sb.delete();
        exp_ovf = 0;
        for (int i = 0; i < 6; i++) m_cnt[i] = 0;
        check("rst_valid", rec_valid, 0);
        check("rst_rec", {rec_type, rec_tag, rec_a, rec_b}, 0);
        check("rst_overflow", overflow, 0);
        check("rst_done", done, 0);
        rst = 0;
    endtask

    // After the halt cycle: junk inputs (must be ignored), ready random (mode 0) or toggling (mode 1).
    task automatic drain_to_done(input int mode);
        int w = 0;
        while (!done && w < 400) begin
            random_inputs();
            halt = 1'($urandom);
            rec_ready = (mode == 1) ? w[0] : 1'($urandom);
            next_cycle();
            w++;
        end
        check("done_reached", done, 1);
        check("done_valid", rec_valid, 0);
        check("sb_left", sb.size(), 0);
        check("overflow_end", overflow, exp_ovf);
    endtask

    // Monitor: pops the scoreboard on every transfer and enforces stream stability.
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 0;
        end else begin
            cur = {rec_type, rec_tag, rec_a, rec_b};
            if (hold_pending) begin
                check("hold_valid", rec_valid, 1);
                check("hold_stable", cur, held);
            end
            if (rec_valid && rec_ready) begin
                hold_pending = 0;
                if (sb.size() == 0) begin
                    check("unexpected_rec", cur, 37'h0);
                    check("unexpected_rec_count", 1, 0);
                end else begin
                    exp_rec = sb.pop_front();
                    check("record", cur, exp_rec);
                end
            end else if (rec_valid) begin
                hold_pending = 1;
                held = cur;
            end else begin
                hold_pending = 0;
            end
        end
    end

    initial begin
        do_reset();

        // T1: single REG record, one-cycle latency
        rec_ready = 1;
        reg_write = 1; write_reg = 3; write_data = 16'h1234;
        check("t1_valid_before", rec_valid, 0);
        model_run();
        next_cycle();
        idle_inputs();
        check("t1_valid", rec_valid, 1);
        check("t1_rec", {rec_type, rec_tag, rec_a, rec_b}, {2'd0, 3'd3, 16'h1234, 16'h0000});
        model_run();
        next_cycle();

        // T2: REG + LOAD + STORE in one cycle
        reg_write = 1; write_reg = 1; write_data = 16'hBEEF;
        mem_read = 1; mem_write = 1; mem_addr = 16'h0040;
        mem_data_out = 16'hBEEF; mem_data_in = 16'h5A5A;
        model_run();
        next_cycle();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            model_run();
            next_cycle();
        end
        check("t2_empty", rec_valid, 0);

        // T3: sink stalled, third burst of three records must be dropped
        rec_ready = 0;
        for (int i = 0; i < 3; i++) begin
            random_inputs();
            reg_write = 1; mem_read = 1; mem_write = 1;
            model_run();
            next_cycle();
        end
        idle_inputs();
        check("t3_overflow", overflow, 1);
        model_run();
        next_cycle();

        // Random traffic, then halt with a random ready pattern through drain and stats
        for (int i = 0; i < 150; i++) begin
            random_inputs();
            rec_ready = ($urandom_range(0, 3) != 0);
            model_run();
            next_cycle();
        end
        random_inputs();
        halt = 1;
        model_run();
        next_cycle();
        drain_to_done(0);

        // T4: 10 cycles, 4 reg writes, halt on cycle 10; ready toggles during stats
        do_reset();
        rec_ready = 1;
        for (int c = 1; c <= 10; c++) begin
            idle_inputs();
            reg_write = (c == 2 || c == 4 || c == 6 || c == 8);
            write_reg = 3'($urandom);
            write_data = 16'($urandom);
            halt = (c == 10);
            model_run();
            next_cycle();
        end
        drain_to_done(1);

        // T6: reset while draining with three entries queued
        do_reset();
        random_inputs();
        reg_write = 1; mem_read = 1; mem_write = 1;
        model_run();
        next_cycle();
        idle_inputs();
        halt = 1;
        model_run();
        next_cycle();
        idle_inputs();
        check("t6_drain_valid", rec_valid, 1);
        rst = 1;
        next_cycle();
        sb.delete();
        exp_ovf = 0;
        for (int i = 0; i < 6; i++) m_cnt[i] = 0;
        check("t6_valid", rec_valid, 0);
        check("t6_done", done, 0);
        check("t6_overflow", overflow, 0);
        rst = 0;
        rec_ready = 1;
        for (int c = 1; c <= 3; c++) begin
            random_inputs();
            halt = (c == 3);
            model_run();
            next_cycle();
        end
        drain_to_done(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
